// File: rtl/blade_ignition_seq_if.sv
// Bundles the sequencer's user, length, power and colour inputs with its
// emitter-driver outputs. The master side drives inputs; the slave side is the sequencer.
interface blade_ignition_seq_if;
    logic       ignite;
    logic [1:0] len_int;
    logic [5:0] len_frac;
    logic [7:0] power_in;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic [3:0] lit_count;
    logic       blade_on;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic       ext_done;
    logic       ret_done;

    modport master (
        output ignite, len_int, len_frac, power_in, r_in, g_in, b_in,
        input  lit_count, blade_on, r_out, g_out, b_out, ext_done, ret_done
    );

    modport slave (
        input  ignite, len_int, len_frac, power_in, r_in, g_in, b_in,
        output lit_count, blade_on, r_out, g_out, b_out, ext_done, ret_done
    );
endinterface

// File: rtl/blade_ignition_seq.sv
// Blade ignition/retraction sequencer: lights segments one step at a time up to
// the latched length, holds, retracts on command or low power, drives colour.
module blade_ignition_seq #(
    parameter int STEP_CYCLES = 4,
    parameter int LOW_PWR     = 8,
    parameter int DIM_PWR     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    blade_ignition_seq_if.slave  bus
);
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_EXTEND,
        S_ON,
        S_RETRACT
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        lit_q, lit_d;
    logic [3:0]        tgt_q, tgt_d;
    logic              blade_on_q, blade_on_d;
    logic [7:0]        r_out_q, r_out_d;
    logic [7:0]        g_out_q, g_out_d;
    logic [7:0]        b_out_q, b_out_d;
    logic              ext_done_q, ext_done_d;
    logic              ret_done_q, ret_done_d;

    logic [3:0] tgt_in;
    logic       pwr_dead;
    logic       pwr_low;
    logic       pwr_dim;
    logic       step_end;
    logic [3:0] lit_up;
    logic [3:0] lit_dn;

    assign tgt_in   = {bus.len_int, bus.len_frac[5:4]};
    assign pwr_dead = (bus.power_in == 8'd0);
    assign pwr_low  = (bus.power_in <= 8'(LOW_PWR));
    assign pwr_dim  = (bus.power_in < 8'(DIM_PWR));
    assign step_end = (step_q == STEP_LAST);

    // Saturating neighbours of lit_count so it can never wrap past tgt_q or 0
    assign lit_up = (lit_q >= tgt_q) ? tgt_q : lit_q + 4'd1;
    assign lit_dn = (lit_q == 4'd0) ? 4'd0 : lit_q - 4'd1;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        lit_d      = lit_q;
        tgt_d      = tgt_q;
        ext_done_d = 1'b0;
        ret_done_d = 1'b0;

        if (pwr_dead) begin
            state_d = S_OFF;
            lit_d   = 4'd0;
            step_d  = '0;
        end else if (pwr_low && (state_q == S_EXTEND || state_q == S_ON)) begin
            state_d = S_RETRACT;
            step_d  = '0;
        end else if (bus.ignite && !pwr_low) begin
            unique case (state_q)
                S_OFF: begin
                    if (tgt_in != 4'd0) begin
                        state_d = S_EXTEND;
                        tgt_d   = tgt_in;
                        step_d  = '0;
                    end
                end
                S_EXTEND, S_ON: begin
                    state_d = S_RETRACT;
                    step_d  = '0;
                end
                S_RETRACT: begin
                    state_d = S_EXTEND;
                    step_d  = '0;
                end
                default: state_d = S_OFF;
            endcase
        end else begin
            unique case (state_q)
                S_EXTEND: begin
                    if (step_end) begin
                        step_d = '0;
                        lit_d  = lit_up;
                        if (lit_up == tgt_q) begin
                            state_d    = S_ON;
                            ext_done_d = 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_RETRACT: begin
                    if (step_end) begin
                        step_d = '0;
                        lit_d  = lit_dn;
                        if (lit_dn == 4'd0) begin
                            state_d    = S_OFF;
                            ret_done_d = 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: begin
                    step_d = '0;
                end
            endcase
        end
    end

    // Colour drive follows the currently lit state, halved when power is dim
    always_comb begin
        r_out_d    = 8'd0;
        g_out_d    = 8'd0;
        b_out_d    = 8'd0;
        blade_on_d = (state_d == S_ON);
        if (lit_q != 4'd0) begin
            if (pwr_dim) begin
                r_out_d = bus.r_in >> 1;
                g_out_d = bus.g_in >> 1;
                b_out_d = bus.b_in >> 1;
            end else begin
                r_out_d = bus.r_in;
                g_out_d = bus.g_in;
                b_out_d = bus.b_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            step_q     <= '0;
            lit_q      <= 4'd0;
            tgt_q      <= 4'd0;
            blade_on_q <= 1'b0;
            r_out_q    <= 8'd0;
            g_out_q    <= 8'd0;
            b_out_q    <= 8'd0;
            ext_done_q <= 1'b0;
            ret_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            lit_q      <= lit_d;
            tgt_q      <= tgt_d;
            blade_on_q <= blade_on_d;
            r_out_q    <= r_out_d;
            g_out_q    <= g_out_d;
            b_out_q    <= b_out_d;
            ext_done_q <= ext_done_d;
            ret_done_q <= ret_done_d;
        end
    end

    assign bus.lit_count = lit_q;
    assign bus.blade_on  = blade_on_q;
    assign bus.r_out     = r_out_q;
    assign bus.g_out     = g_out_q;
    assign bus.b_out     = b_out_q;
    assign bus.ext_done  = ext_done_q;
    assign bus.ret_done  = ret_done_q;

endmodule

// File: tb/tb_blade_ignition_seq.sv
// Directed bench for blade_ignition_seq with hand-computed expectations.
module tb_blade_ignition_seq;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   ext_count;
    int   ret_count;

    blade_ignition_seq_if bus ();

    blade_ignition_seq #(
        .STEP_CYCLES(4),
        .LOW_PWR    (8),
        .DIM_PWR    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, sampling 1ns after each and tallying done pulses
    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.ext_done === 1'b1) ext_count++;
            if (bus.ret_done === 1'b1) ret_count++;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pressIgnite();
        bus.ignite = 1'b1;
        tickN(1);
        bus.ignite = 1'b0;
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        ext_count    = 0;
        ret_count    = 0;
        rst          = 1'b1;
        bus.ignite   = 1'b0;
        bus.len_int  = 2'd1;
        bus.len_frac = 6'd50;
        bus.power_in = 8'd200;
        bus.r_in     = 8'd255;
        bus.g_in     = 8'd255;
        bus.b_in     = 8'd255;
        tickN(2);
        checkOutput("reset_lit", bus.lit_count, 0);
        checkOutput("reset_on", bus.blade_on, 0);
        checkOutput("reset_r", bus.r_out, 0);
        checkOutput("reset_done", {bus.ext_done, bus.ret_done}, 0);
        rst = 1'b0;
        tickN(1);
        ext_count = 0;
        ret_count = 0;

        // Ignite, target 7
        pressIgnite();
        tickN(3);
        checkOutput("ext_first_wait", bus.lit_count, 0);
        tickN(1);
        checkOutput("ext_first_seg", bus.lit_count, 1);
        tickN(23);
        checkOutput("ext_lit6", bus.lit_count, 6);
        checkOutput("ext_not_on", bus.blade_on, 0);
        tickN(1);
        checkOutput("ext_full", bus.lit_count, 7);
        checkOutput("ext_done_pulse", bus.ext_done, 1);
        checkOutput("ext_blade_on", bus.blade_on, 1);
        checkOutput("ext_count", ext_count, 1);
        checkOutput("on_r_full", bus.r_out, 255);
        tickN(1);
        checkOutput("ext_done_single", bus.ext_done, 0);

        // Dimming
        bus.power_in = 8'd20;
        tickN(1);
        checkOutput("dim_r", bus.r_out, 127);
        checkOutput("dim_g", bus.g_out, 127);
        checkOutput("dim_b", bus.b_out, 127);
        checkOutput("dim_still_on", bus.blade_on, 1);
        bus.power_in = 8'd200;
        tickN(1);
        checkOutput("undim_r", bus.r_out, 255);

        // Retract from ON
        ret_count = 0;
        pressIgnite();
        checkOutput("ret_off_on", bus.blade_on, 0);
        tickN(4);
        checkOutput("ret_lit6", bus.lit_count, 6);
        tickN(23);
        checkOutput("ret_lit1", bus.lit_count, 1);
        tickN(1);
        checkOutput("ret_lit0", bus.lit_count, 0);
        checkOutput("ret_done_pulse", bus.ret_done, 1);
        tickN(1);
        checkOutput("ret_count", ret_count, 1);
        checkOutput("ret_r_zero", bus.r_out, 0);

        // Reverse mid-extend, then reverse again
        ext_count = 0;
        pressIgnite();
        tickN(12);
        checkOutput("rev_lit3", bus.lit_count, 3);
        pressIgnite();
        tickN(4);
        checkOutput("rev_lit2", bus.lit_count, 2);
        pressIgnite();
        tickN(19);
        checkOutput("rev_lit6", bus.lit_count, 6);
        tickN(1);
        checkOutput("rev_lit7", bus.lit_count, 7);
        checkOutput("rev_on", bus.blade_on, 1);
        checkOutput("rev_ext_count", ext_count, 1);

        // Low power forces retract, ignition refused
        ret_count    = 0;
        bus.power_in = 8'd5;
        tickN(1);
        checkOutput("lowpwr_not_on", bus.blade_on, 0);
        tickN(28);
        checkOutput("lowpwr_lit0", bus.lit_count, 0);
        checkOutput("lowpwr_ret_count", ret_count, 1);
        pressIgnite();
        tickN(8);
        checkOutput("lowpwr_refuse", bus.lit_count, 0);

        // Power loss mid-extend
        bus.power_in = 8'd200;
        pressIgnite();
        tickN(8);
        checkOutput("dead_pre", bus.lit_count, 2);
        ret_count    = 0;
        bus.power_in = 8'd0;
        tickN(1);
        checkOutput("dead_lit0", bus.lit_count, 0);
        tickN(3);
        checkOutput("dead_no_ret", ret_count, 0);

        // Length 10, later length changes ignored
        bus.power_in = 8'd200;
        bus.len_int  = 2'd2;
        bus.len_frac = 6'd33;
        pressIgnite();
        tickN(40);
        checkOutput("len10_lit", bus.lit_count, 10);
        checkOutput("len10_on", bus.blade_on, 1);
        bus.len_int  = 2'd0;
        bus.len_frac = 6'd0;
        tickN(8);
        checkOutput("len_change_hold", bus.lit_count, 10);
        bus.power_in = 8'd0;
        tickN(1);
        bus.power_in = 8'd200;
        ext_count    = 0;
        pressIgnite();
        tickN(8);
        checkOutput("zero_len_lit", bus.lit_count, 0);
        checkOutput("zero_len_ext", ext_count, 0);

        // Reset mid-extend
        bus.len_int  = 2'd1;
        bus.len_frac = 6'd50;
        pressIgnite();
        tickN(8);
        checkOutput("rst_mid_pre", bus.lit_count, 2);
        rst = 1'b1;
        tickN(1);
        checkOutput("rst_mid_lit", bus.lit_count, 0);
        checkOutput("rst_mid_done", {bus.ext_done, bus.ret_done}, 0);
        rst = 1'b0;
        tickN(8);
        checkOutput("rst_mid_stay", bus.lit_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
